// File: rtl/kpn_channel_fifo_pkg.sv
// Shared constants for the KPN process network: token width, default
// channel geometry, and the per-cycle channel operation encoding.
package kpn_channel_fifo_pkg;

    localparam int TOKEN_WIDTH         = 16;
    localparam int DEFAULT_DEPTH       = 8;
    localparam int DEFAULT_ADDR_WIDTH  = $clog2(DEFAULT_DEPTH);
    localparam int DEFAULT_ALMOST_FULL = DEFAULT_DEPTH - 2;

    // Accepted operations in one cycle, encoded as {write, read}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } chan_op_e;

endpackage

// File: rtl/kpn_fifo_ram.sv
// Simple dual-port register array for channel token storage.
// One synchronous write port and one asynchronous (combinational) read port.
module kpn_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Write port: store the token on the clock edge when enabled.
    // NOTE: storage has no reset; every slot is written before it can be read,
    // and leaving it out lets the array map onto plain flops or distributed RAM.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment, so a same-edge read sees the old word.
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/kpn_channel_fifo.sv
// Bounded FIFO channel between two KPN processes. Reads from an empty
// channel and writes to a full channel are refused, flagged with sticky
// status bits, and leave the stored tokens untouched.
module kpn_channel_fifo
    import kpn_channel_fifo_pkg::*;
#(
    parameter int DATA_WIDTH        = TOKEN_WIDTH,
    parameter int DEPTH             = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH        = DEFAULT_ADDR_WIDTH,
    parameter int ALMOST_FULL_LEVEL = DEFAULT_ALMOST_FULL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                CW       = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = CW'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = CW'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  rd_ok;
    logic                  wr_ok;
    chan_op_e              op;

    // Status decoded from the registered count, valid before the edge.
    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almost_full = (count >= AFULL_C);

    // A read frees a slot in the same cycle, so a full channel still takes a write.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);
    assign op    = chan_op_e'({wr_ok, rd_ok});

    // Next occupancy: up on write-only, down on read-only, else hold.
    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch forms.
        count_next = count;
        case (op)
            OP_WRITE: count_next = count + CNT_ONE;
            OP_READ:  count_next = count - CNT_ONE;
            default:  count_next = count;
        endcase
    end

    // Pointers, occupancy, output register and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_next;
            data_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rdata;
            end
            if (wr && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Token storage; writes are suppressed while the channel is in reset.
    kpn_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok && !reset),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule
